// File: rtl/trena_pkg.sv
// Shared definitions for the trena control unit: state codes, character
// select codes and timing defaults.
package trena_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ESPERA_MEDIDA = 4'd2,
        TRANSMITE     = 4'd3,
        ESPERA_TX     = 4'd4,
        PROXIMO       = 4'd5,
        FINAL         = 4'd6,
        ESPERA_AUTO   = 4'd7,
        ERRO          = 4'd8
    } estado_t;

    localparam logic [1:0] SEL_CENTENA = 2'd0;
    localparam logic [1:0] SEL_DEZENA  = 2'd1;
    localparam logic [1:0] SEL_UNIDADE = 2'd2;
    localparam logic [1:0] SEL_HASH    = 2'd3;

    localparam logic [6:0] ASCII_HASH = 7'h23;

    localparam int TIMEOUT_M_DEF = 2500000;
    localparam int TIMEOUT_N_DEF = 22;

endpackage

// File: rtl/trena_uc_contador_m.sv
// Modulo-M up counter with synchronous clear; used as the measurement timeout.
module contador_m #(
    parameter int M = 2500000,
    parameter int N = 22
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] LAST = N'(M - 1);
    localparam logic [N-1:0] ONE  = N'(1);

    always_ff @(posedge clock) begin
        if (!reset || zera_s) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == LAST) ? '0 : q + ONE;
        end
    end

endmodule

// File: rtl/trena_uc.sv
// Control unit for the trena datapath: sequences the measurement, the
// four-character serial report and the periodic auto mode.
module trena_uc
    import trena_pkg::*;
#(
    parameter int TIMEOUT_M = TIMEOUT_M_DEF,
    parameter int TIMEOUT_N = TIMEOUT_N_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mensurar,
    input  logic       modo_auto,
    input  logic       pronto_medida,
    input  logic       pronto_serial,
    input  logic       fim_auto,
    output logic       medir_dp,
    output logic       partida_serial,
    output logic [1:0] sel_letra,
    output logic       zera_auto,
    output logic       conta_auto,
    output logic       pronto,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam logic [TIMEOUT_N-1:0] TO_LAST = TIMEOUT_N'(TIMEOUT_M - 1);

    estado_t               estado, prox;
    logic [1:0]            nxt_sel;
    logic                  nxt_erro;
    logic                  zera_t, conta_t;
    logic [TIMEOUT_N-1:0]  cnt_t;
    logic                  timeout;

    contador_m #(
        .M(TIMEOUT_M),
        .N(TIMEOUT_N)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .zera_s (zera_t),
        .conta  (conta_t),
        .q      (cnt_t)
    );

    assign timeout   = (cnt_t == TO_LAST);
    assign db_estado = estado;

    always_comb begin
        prox     = estado;
        nxt_sel  = sel_letra;
        nxt_erro = erro;
        zera_t   = 1'b0;
        conta_t  = 1'b0;
        case (estado)
            INICIAL:       if (mensurar) prox = PREPARA;
            PREPARA: begin
                zera_t = 1'b1;
                prox   = ESPERA_MEDIDA;
            end
            ESPERA_MEDIDA: begin
                conta_t = 1'b1;
                if (pronto_medida)  prox = TRANSMITE;
                else if (timeout)   prox = ERRO;
            end
            TRANSMITE:     prox = ESPERA_TX;
            ESPERA_TX:     if (pronto_serial) prox = PROXIMO;
            PROXIMO: begin
                if (sel_letra == SEL_HASH) begin
                    prox = FINAL;
                end else begin
                    prox    = TRANSMITE;
                    nxt_sel = sel_letra + 2'd1;
                end
            end
            FINAL:         prox = modo_auto ? ESPERA_AUTO : INICIAL;
            ESPERA_AUTO: begin
                if (!modo_auto) begin
                    prox = INICIAL;
                end else if (fim_auto) begin
                    // Auto restart skips PREPARA, so it must rewind the
                    // character select itself or the report would start at '#'.
                    prox     = ESPERA_MEDIDA;
                    zera_t   = 1'b1;
                    nxt_erro = 1'b0;
                    nxt_sel  = SEL_CENTENA;
                end else if (mensurar) begin
                    prox = PREPARA;
                end
            end
            ERRO:          prox = INICIAL;
            default:       prox = INICIAL;
        endcase
        if (prox == PREPARA) begin
            nxt_sel  = SEL_CENTENA;
            nxt_erro = 1'b0;
        end
        if (prox == ERRO) nxt_erro = 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    // zera_auto is raised on every FINAL: clearing the 1 s timer is harmless
    // in manual mode and avoids depending on modo_auto a cycle early.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado         <= INICIAL;
            sel_letra      <= SEL_CENTENA;
            erro           <= 1'b0;
            medir_dp       <= 1'b0;
            partida_serial <= 1'b0;
            zera_auto      <= 1'b0;
            conta_auto     <= 1'b0;
            pronto         <= 1'b0;
        end else begin
            estado         <= prox;
            sel_letra      <= nxt_sel;
            erro           <= nxt_erro;
            medir_dp       <= (prox == PREPARA);
            partida_serial <= (prox == TRANSMITE);
            zera_auto      <= (prox == PREPARA) || (prox == FINAL);
            conta_auto     <= (prox == ESPERA_AUTO);
            pronto         <= (prox == FINAL);
        end
    end

endmodule

// File: tb/tb_trena_uc.sv
// Directed bench for trena_uc with a small behavioural datapath responder.
module tb_trena_uc;

    localparam int AUTO_M   = 1000;
    localparam int TX_DELAY = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       mensurar = 1'b0;
    logic       modo_auto = 1'b0;
    logic       pronto_medida = 1'b0;
    logic       pronto_serial = 1'b0;
    logic       fim_auto = 1'b0;
    logic       medir_dp, partida_serial, zera_auto, conta_auto, pronto, erro;
    logic [1:0] sel_letra;
    logic [3:0] db_estado;

    trena_uc #(
        .TIMEOUT_M(50),
        .TIMEOUT_N(22)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .mensurar       (mensurar),
        .modo_auto      (modo_auto),
        .pronto_medida  (pronto_medida),
        .pronto_serial  (pronto_serial),
        .fim_auto       (fim_auto),
        .medir_dp       (medir_dp),
        .partida_serial (partida_serial),
        .sel_letra      (sel_letra),
        .zera_auto      (zera_auto),
        .conta_auto     (conta_auto),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Written by the responder process only.
    int cyc = 0, med_cnt = 0, tx_cnt = 0, tmr = 0;
    int n_partida = 0, n_pronto = 0, n_medir = 0, n_final = 0, n_zera_final = 0;
    int cyc_ps3 = 0, cyc_pronto = 0;
    logic [1:0] sel_log[$];

    // Written by the stimulus process only.
    int   meas_delay = 30;
    logic meas_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (db_estado == target) break;
        end
        check(tag, 32'(db_estado), 32'(target));
    endtask

    task automatic pulse_mensurar();
        mensurar = 1'b1;
        tick();
        mensurar = 1'b0;
    endtask

    // Datapath responder: measurement, serial TX and 1 s timer models.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            pronto_medida = 1'b0;
            pronto_serial = 1'b0;
            fim_auto      = 1'b0;
            if (med_cnt > 0) begin
                med_cnt--;
                if (med_cnt == 0) pronto_medida = meas_en;
            end
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    pronto_serial = 1'b1;
                    if (sel_letra == 2'd3) cyc_ps3 = cyc;
                end
            end
            if (zera_auto) begin
                tmr = 0;
            end else if (conta_auto) begin
                if (tmr == AUTO_M - 1) begin
                    tmr = 0;
                    fim_auto = 1'b1;
                end else begin
                    tmr++;
                end
            end
            if (medir_dp || fim_auto) med_cnt = meas_delay;
            if (partida_serial) begin
                tx_cnt = TX_DELAY;
                n_partida++;
                sel_log.push_back(sel_letra);
            end
            if (medir_dp) n_medir++;
            if (pronto) begin
                n_pronto++;
                cyc_pronto = cyc;
            end
            if (db_estado == 4'd6) begin
                n_final++;
                if (zera_auto) n_zera_final++;
            end
        end
    end

    initial begin
        int b_part, b_pronto, b_medir, b_zf;
        int k;

        // 1: reset with mensurar held high, then release
        reset = 1'b0;
        mensurar = 1'b1;
        tick();
        tick();
        check("rst_state", 32'(db_estado), 0);
        check("rst_outs", 32'({medir_dp, partida_serial, zera_auto, conta_auto, pronto, erro, sel_letra}), 0);
        reset = 1'b1;
        tick();
        check("rel_state1", 32'(db_estado), 1);
        check("rel_medir_hi", 32'(medir_dp), 1);
        mensurar = 1'b0;
        tick();
        check("rel_medir_lo", 32'(medir_dp), 0);
        check("rel_state2", 32'(db_estado), 2);

        // 2: manual measurement and four-character report
        wait_state("man_done", 4'd0, 1000);
        check("man_partidas", 32'(n_partida), 4);
        for (int i = 0; i < 4; i++) check("man_sel", 32'(sel_log[i]), 32'(i));
        check("man_pronto", 32'(n_pronto), 1);
        check("man_pronto_lat", 32'(cyc_pronto - cyc_ps3), 2);
        check("man_sel_hold", 32'(sel_letra), 3);
        check("man_erro", 32'(erro), 0);

        // 5: pronto_medida on the exact timeout cycle wins
        meas_delay = 50;
        pulse_mensurar();
        wait_state("race_em", 4'd2, 10);
        k = 0;
        while (db_estado == 4'd2 && k < 200) begin
            tick();
            k++;
        end
        check("race_lat", 32'(k), 50);
        check("race_state", 32'(db_estado), 3);
        check("race_erro", 32'(erro), 0);
        wait_state("race_done", 4'd0, 1000);
        check("race_erro_end", 32'(erro), 0);

        // 4: no response -> timeout after 50 cycles
        meas_en = 1'b0;
        b_part = n_partida;
        pulse_mensurar();
        wait_state("to_em", 4'd2, 10);
        k = 0;
        while (db_estado == 4'd2 && k < 200) begin
            tick();
            k++;
        end
        check("to_lat", 32'(k), 50);
        check("to_state", 32'(db_estado), 8);
        tick();
        check("to_back", 32'(db_estado), 0);
        check("to_erro", 32'(erro), 1);
        check("to_no_tx", 32'(n_partida - b_part), 0);
        meas_en = 1'b1;
        meas_delay = 30;
        pulse_mensurar();
        tick();
        check("to_clear", 32'(erro), 0);
        wait_state("to_done", 4'd0, 1000);

        // 3: auto mode, three full cycles
        b_part = n_partida;
        b_pronto = n_pronto;
        b_medir = n_medir;
        b_zf = n_zera_final;
        modo_auto = 1'b1;
        pulse_mensurar();
        k = 0;
        while (n_pronto - b_pronto < 3 && k < 6000) begin
            tick();
            k++;
        end
        check("auto_prontos", 32'(n_pronto - b_pronto), 3);
        check("auto_partidas", 32'(n_partida - b_part), 12);
        for (int i = 0; i < 12; i++) check("auto_sel", 32'(sel_log[b_part + i]), 32'(i % 4));
        check("auto_medir", 32'(n_medir - b_medir), 1);
        check("auto_zera_final", 32'(n_zera_final - b_zf), 3);
        modo_auto = 1'b0;
        wait_state("auto_exit", 4'd0, 2000);

        // 6: reset in ESPERA_TX while sending the third character
        pulse_mensurar();
        k = 0;
        while (!(db_estado == 4'd4 && sel_letra == 2'd2) && k < 1000) begin
            tick();
            k++;
        end
        check("rtx_reach", 32'({db_estado, sel_letra}), 32'({4'd4, 2'd2}));
        reset = 1'b0;
        tick();
        check("rtx_state", 32'(db_estado), 0);
        check("rtx_sel", 32'(sel_letra), 0);
        reset = 1'b1;
        b_part = n_partida;
        b_pronto = n_pronto;
        repeat (100) tick();
        check("rtx_no_pronto", 32'(n_pronto - b_pronto), 0);
        check("rtx_no_tx", 32'(n_partida - b_part), 0);
        check("rtx_idle", 32'(db_estado), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
